alu_op_driver: RTL and testbench

//  Initiator side of the ALU operand/select interface. Accepts one operation

---
 rtl/alu_op_driver_if.sv | 26 ++
 rtl/alu_op_driver.sv | 69 ++++++
 tb/tb_alu_op_driver.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_driver_if.sv
// alu_op_driver_if: request, ALU operand/result and response signals of the ALU op driver.
interface alu_op_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic [3:0] rsp_sel;
    modport master (
        input  req_valid, req_a, req_b, req_sel, alu_out, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_sel
    );
    modport slave (
        output req_valid, req_a, req_b, req_sel, alu_out, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_sel
    );
endinterface

// File: rtl/alu_op_driver.sv
// alu_op_driver: issues one ALU operation at a time and returns its result over a valid/ready port.
module alu_op_driver #(
    parameter int ALU_LAT   = 1,
    parameter int MUL_EXTRA = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_driver_if.master  bus,
    output logic [CNT_W-1:0] op_count
);
    localparam int WC_W = $clog2(ALU_LAT + MUL_EXTRA + 2);
    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [WC_W-1:0] wait_cnt;
    logic req_fire, done, rsp_fire;
    assign req_fire = (state == IDLE) && bus.req_valid;
    assign done     = (state == WAIT) && (wait_cnt == '0);
    assign rsp_fire = (state == RESP) && bus.rsp_ready;
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                state_nx      = bus.req_valid ? DRIVE : IDLE;
            end
            DRIVE:   state_nx = WAIT;
            WAIT:    state_nx = (wait_cnt == '0) ? RESP : WAIT;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // Result is taken once the counter has run down, giving the ALU its full latency after DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_sel    <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_sel    <= '0;
            op_count       <= '0;
        end else begin
            state <= state_nx;
            if (req_fire) begin
                bus.alu_a   <= bus.req_a;
                bus.alu_b   <= bus.req_b;
                bus.alu_sel <= bus.req_sel;
                wait_cnt    <= WC_W'(ALU_LAT + ((bus.req_sel == 4'd2) ? MUL_EXTRA : 0));
            end
            if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (done) begin
                bus.rsp_result <= bus.alu_out;
                bus.rsp_carry  <= bus.alu_carry & (bus.alu_sel == 4'd0);
                bus.rsp_sel    <= bus.alu_sel;
                bus.rsp_valid  <= 1'b1;
            end
            if (rsp_fire) begin
                bus.rsp_valid <= 1'b0;
                op_count      <= op_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed scoreboard bench for alu_op_driver against a registered ALU model.
module tb_alu_op_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] op_count;
    logic [1:0]  op_count2;
    int n_assert = 0;
    int n_fail = 0;
    int exp_count = 0;
    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic [3:0] sel;
    } exp_t;
    exp_t sb[$];
    logic [7:0] r;
    int seen;
    alu_op_driver_if bus();
    alu_op_driver_if bus2();
    alu_op_driver #(.ALU_LAT(1), .MUL_EXTRA(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .op_count(op_count));
    alu_op_driver #(.ALU_LAT(1), .MUL_EXTRA(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .op_count(op_count2));
    assign bus2.req_valid = bus.req_valid;
    assign bus2.req_a     = bus.req_a;
    assign bus2.req_b     = bus.req_b;
    assign bus2.req_sel   = bus.req_sel;
    assign bus2.rsp_ready = bus.rsp_ready;
    assign bus2.alu_out   = bus.alu_out;
    assign bus2.alu_carry = bus.alu_carry;
    always #5 clk = ~clk;
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return a / b;
            4'd4:  return a << 1;
            4'd5:  return a >> 1;
            4'd6:  return {a[6:0], a[7]};
            4'd7:  return {a[0], a[7:1]};
            4'd8:  return a & b;
            4'd9:  return a | b;
            4'd10: return a ^ b;
            4'd11: return ~(a | b);
            4'd12: return ~(a & b);
            4'd13: return ~(a ^ b);
            4'd14: return (a > b) ? 8'd1 : 8'd0;
            default: return (a == b) ? 8'd1 : 8'd0;
        endcase
    endfunction
    function automatic logic carry_f(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[8];
    endfunction
    // ALU stand-in: one registered stage, carry driven for every select so masking is visible.
    always_ff @(posedge clk) begin
        bus.alu_out   <= alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
        bus.alu_carry <= carry_f(bus.alu_a, bus.alu_b);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input int hold, output logic [7:0] res);
        int n;
        exp_t e;
        @(negedge clk);
        bus.req_a = a;
        bus.req_b = b;
        bus.req_sel = s;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (hold == 0);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", bus.req_ready, 1);
        sb.push_back('{res: alu_f(a, b, s), c: (s == 4'd0) ? carry_f(a, b) : 1'b0, sel: s});
        @(negedge clk);
        bus.req_valid = (hold > 0);
        bus.req_a = ~a;
        bus.req_b = ~b;
        chk("req_ready_busy", bus.req_ready, 0);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, (s == 4'd2) ? 4 : 3);
        e = sb.pop_front();
        res = bus.rsp_result;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_result", bus.rsp_result, e.res);
            chk("hold_req_ready", bus.req_ready, 0);
            chk("hold_alu_a", bus.alu_a, a);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_result", bus.rsp_result, e.res);
        chk("rsp_carry", bus.rsp_carry, e.c);
        chk("rsp_sel", bus.rsp_sel, e.sel);
        @(negedge clk);
        bus.req_valid = 1'b0;
        exp_count++;
        chk("rsp_valid_drop", bus.rsp_valid, 0);
        chk("op_count", op_count, exp_count[15:0]);
        chk("op_count_w2", op_count2, exp_count[1:0]);
        chk("req_ready_back", bus.req_ready, 1);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        sb.delete();
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_sel = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_carry", bus.rsp_carry, 0);
        chk("rst_rsp_sel", bus.rsp_sel, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        op(8'd7, 8'd3, 4'd1, 0, r);
        @(negedge clk);
        bus.req_a = 8'd12;
        bus.req_b = 8'd10;
        bus.req_sel = 4'd2;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        chk("mid_rst_alu_sel", bus.alu_sel, 0);
        chk("mid_rst_rsp_result", bus.rsp_result, 0);
        chk("mid_rst_op_count", op_count, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        chk("mid_rst_count_after", op_count, 0);
        op(8'd200, 8'd100, 4'd0, 0, r);
        chk("add_result", r, 8'd44);
        chk("add_carry", bus.rsp_carry, 1);
        op(8'd12, 8'd10, 4'd2, 0, r);
        chk("mul_result", r, 8'd120);
        chk("mul_carry", bus.rsp_carry, 0);
        op(8'd255, 8'd255, 4'd15, 5, r);
        chk("eq_result", r, 8'd1);
        chk("eq_carry_masked", bus.rsp_carry, 0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            op(8'hA5, 8'h3C, 4'(i), 0, r);
            if (i == 10) chk("xor_result", r, 8'h99);
            if (i == 6) chk("rol_result", r, 8'h4B);
            if (i == 4) chk("wrap_after_5", op_count2, 2'd1);
        end
        chk("count_16", op_count, 16'd16);
        chk("count_w2_16", op_count2, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
